// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive four-state equivalence sweep: drives every 4-lane {0,1,x,z} stimulus
// to a spec and an impl copy, compares after settling, and records mismatch statistics.
module equiv_sweep_ctrl #(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned OUTW   = 24
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [7:0]      stim_code,
   output logic            stim_valid,
   input  logic [OUTW-1:0] spec_val,
   input  logic [OUTW-1:0] impl_val,
   input  logic [OUTW-1:0] spec_unk,
   input  logic [OUTW-1:0] impl_unk,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            mismatch,
   output logic [8:0]      fail_count,
   output logic [7:0]      first_fail_vec,
   output logic [OUTW-1:0] first_fail_mask
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t            state_r;
   state_t            state_nxt;
   logic [7:0]        idx_r;
   logic [7:0]        idx_nxt;
   logic [7:0]        settle_cnt_r;
   logic [7:0]        settle_cnt_nxt;
   logic [8:0]        fail_count_r;
   logic [8:0]        fail_count_nxt;
   logic [7:0]        first_vec_r;
   logic [7:0]        first_vec_nxt;
   logic [OUTW-1:0]   first_mask_r;
   logic [OUTW-1:0]   first_mask_nxt;
   logic              pass_r;
   logic              pass_nxt;
   logic [OUTW-1:0]   diff_s;

   // State and sweep bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         idx_r        <= 8'd0;
         settle_cnt_r <= 8'd0;
         fail_count_r <= 9'd0;
         first_vec_r  <= 8'd0;
         first_mask_r <= {OUTW{1'b0}};
         pass_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         idx_r        <= idx_nxt;
         settle_cnt_r <= settle_cnt_nxt;
         fail_count_r <= fail_count_nxt;
         first_vec_r  <= first_vec_nxt;
         first_mask_r <= first_mask_nxt;
         pass_r       <= pass_nxt;
      end
   end

   // Next-state, comparison and output decode
   always_comb begin
      state_nxt      = state_r;
      idx_nxt        = idx_r;
      settle_cnt_nxt = settle_cnt_r;
      fail_count_nxt = fail_count_r;
      first_vec_nxt  = first_vec_r;
      first_mask_nxt = first_mask_r;
      pass_nxt       = pass_r;
      mismatch       = 1'b0;
      // x and z share unk=1 and are told apart by the val bit
      diff_s         = (spec_val ^ impl_val) | (spec_unk ^ impl_unk);

      if (abort && (state_r != ST_IDLE)) begin
         state_nxt = ST_IDLE;
         pass_nxt  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_nxt      = ST_APPLY;
                  idx_nxt        = 8'd0;
                  fail_count_nxt = 9'd0;
                  first_vec_nxt  = 8'd0;
                  first_mask_nxt = {OUTW{1'b0}};
                  pass_nxt       = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_APPLY: begin
               state_nxt      = ST_SETTLE;
               settle_cnt_nxt = 8'd0;
            end
            ST_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_nxt = ST_COMPARE;
               end else begin
                  settle_cnt_nxt = settle_cnt_r + 8'd1;
               end
            end
            ST_COMPARE: begin
               if (|diff_s) begin
                  mismatch = 1'b1;
                  if (fail_count_r == 9'd0) begin
                     first_vec_nxt  = idx_r;
                     first_mask_nxt = diff_s;
                  end else begin
                     first_vec_nxt  = first_vec_r;
                  end
                  if (fail_count_r == 9'd256) begin
                     fail_count_nxt = fail_count_r;
                  end else begin
                     fail_count_nxt = fail_count_r + 9'd1;
                  end
               end else begin
                  mismatch = 1'b0;
               end
               if (idx_r == 8'd255) begin
                  state_nxt = ST_DONE;
                  pass_nxt  = (fail_count_nxt == 9'd0);
               end else begin
                  idx_nxt   = idx_r + 8'd1;
                  state_nxt = ST_APPLY;
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end

      stim_valid      = (state_r == ST_APPLY) || (state_r == ST_SETTLE) || (state_r == ST_COMPARE);
      stim_code       = stim_valid ? idx_r : 8'd0;
      busy            = (state_r != ST_IDLE);
      done            = (state_r == ST_DONE) && !abort;
      pass            = pass_r;
      fail_count      = fail_count_r;
      first_fail_vec  = first_vec_r;
      first_fail_mask = first_mask_r;
   end

endmodule

// File: doc/equiv_sweep_ctrl.md
EQUIV_SWEEP_CTRL -- requirements
Module: equiv_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 4: number of clock cycles a stimulus vector is held before the outputs are sampled; legal range 1..255.
REQ-002 Parameter OUTW, default 24: total compared output width, i.e. six 4-bit outputs concatenated.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: sweep request; sampled only in IDLE.
REQ-006 Port abort, input, 1: terminates an active sweep.
REQ-007 Port stim_code, output, 8: four 2-bit lane codes for the datapath input, lane 3 in [7:6] down to lane 0 in [1:0]; lane codes are 00=0, 01=1, 10=x, 11=z.
REQ-008 Port stim_valid, output, 1: stim_code is being driven to the spec and impl copies.
REQ-009 Ports spec_val and impl_val, input, OUTW each: value bit per output bit of the spec copy and the impl copy.
REQ-010 Ports spec_unk and impl_unk, input, OUTW each: unknown flag per output bit; 1 means x or z.
REQ-011 Port busy, output, 1: a sweep is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a full sweep completes.
REQ-013 Port pass, output, 1: the last completed sweep had zero mismatches.
REQ-014 Port mismatch, output, 1: one-cycle pulse in any COMPARE cycle that detects a difference.
REQ-015 Port fail_count, output, 9: number of mismatching vectors in the current or last sweep.
REQ-016 Port first_fail_vec, output, 8: stim_code of the first mismatching vector.
REQ-017 Port first_fail_mask, output, OUTW: differing bit positions of the first mismatching vector.

Function
REQ-018 The FSM SHALL have the states IDLE, APPLY, SETTLE, COMPARE and DONE.
REQ-019 IDLE SHALL move to APPLY on start=1; in that same edge the block SHALL clear the 8-bit index idx, fail_count, first_fail_vec, first_fail_mask and pass.
REQ-020 stim_code SHALL equal idx in APPLY, SETTLE and COMPARE, and SHALL be 0 otherwise.
REQ-021 stim_valid SHALL be 1 exactly in APPLY, SETTLE and COMPARE.
REQ-022 idx SHALL be the mixed-radix counter with lane 0 least significant, so the 256 vectors are swept in the order 0..255.
REQ-023 APPLY SHALL last one cycle and then go to SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE cycles, counted by a settle counter, and then go to COMPARE.
REQ-025 Each vector SHALL therefore take SETTLE+2 cycles, and a full sweep 256*(SETTLE+2) cycles from start to DONE entry.
REQ-026 COMPARE SHALL compute diff = (spec_val^impl_val)|(spec_unk^impl_unk), giving four-state case-inequality semantics with x and z distinguished by the val bit.
REQ-027 If diff is nonzero in COMPARE, mismatch SHALL pulse high for that cycle and fail_count SHALL increment.
REQ-028 On a mismatch with fail_count==0, first_fail_vec SHALL load idx and first_fail_mask SHALL load diff in the same edge; later mismatches SHALL NOT overwrite them.
REQ-029 COMPARE SHALL go to DONE if idx==255; otherwise idx SHALL increment and the FSM SHALL return to APPLY.
REQ-030 DONE SHALL last one cycle with done=1, set pass=(fail_count==0) including any final-vector increment, and return to IDLE.
REQ-031 fail_count SHALL NOT wrap; the maximum of 256 fits in 9 bits.
REQ-032 busy SHALL be 1 in APPLY, SETTLE, COMPARE and DONE, and 0 in IDLE.
REQ-033 start SHALL be ignored while busy=1.
REQ-034 abort=1 in any busy state SHALL force IDLE on the next edge, with no done pulse and pass=0; fail_count and the first-fail fields SHALL hold.
REQ-035 abort SHALL take priority over COMPARE updates in the same cycle, so that cycle's mismatch is not counted.
REQ-036 abort in IDLE SHALL have no effect.
REQ-037 When start and abort are both high in IDLE, start SHALL win.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE and set idx, the settle counter, stim_code, stim_valid, busy, done, pass, mismatch, fail_count, first_fail_vec and first_fail_mask to 0.
REQ-039 Reset asserted mid-sweep SHALL discard all sweep results.
REQ-040 After release the block SHALL wait for a new start.

Verification
REQ-041 Identical spec/impl inputs, SETTLE=4, pulse start -> done at cycle 1536 after start, pass=1, fail_count=0, no mismatch pulses.
REQ-042 impl_unk[0] forced opposite to spec only when stim_code==8'h2E -> exactly one mismatch pulse, fail_count=1, first_fail_vec=8'h2E, first_fail_mask=24'h000001, pass=0.
REQ-043 Difference present on every vector -> fail_count=256 with no wrap, first_fail_vec=8'h00, pass=0.
REQ-044 abort asserted during the COMPARE of vector 8'h10, which mismatches -> IDLE next cycle, that mismatch not counted, no done, pass=0.
REQ-045 rst_n pulsed low asynchronously mid-SETTLE -> all outputs 0 with no clock edge; a start after release begins again at vector 8'h00.
REQ-046 start re-pulsed while busy -> ignored, and the sweep length stays unchanged.
